// File: rtl/button_rate_pkg.sv
// Shared types and constants for the button-driven rate controller.
// Includes the production defaults and the small DEBUG-scale set used in simulation.
package button_rate_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCKED} state_t;

  typedef struct packed {
    logic up;
    logic dn;
  } btn_t;

  localparam int RATE_INIT_DEF = 800000;
  localparam int RATE_MIN_DEF  = 200000;
  localparam int RATE_MAX_DEF  = 3200000;

  localparam int DBG_RATE_INIT       = 10;
  localparam int DBG_RATE_MIN        = 4;
  localparam int DBG_RATE_MAX        = 40;
  localparam int DBG_STEP            = 1;
  localparam int DBG_DEBOUNCE_CYCLES = 4;
  localparam int DBG_REPEAT_DELAY    = 20;
  localparam int DBG_REPEAT_PERIOD   = 5;

  // Acceleration: step doubles after this many consecutive repeat steps.
  localparam int ACCEL_RUN       = 8;
  localparam int ACCEL_MAX_SHIFT = 4;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-level counter for one active-low button.
// pressed is high once the synced input has been low for CYCLES consecutive cycles.
module button_debounce #(
  parameter int CYCLES = 60000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw_n};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/button_rate_ctrl.sv
// Debounced up/down buttons drive a saturating rate value with hold-to-auto-repeat.
// Optional BUTTON_RATE_ACCEL_EN doubles the repeat step every 8 repeats (capped at STEP<<4).
module button_rate_ctrl
  import button_rate_pkg::*;
#(
  parameter int RATE_W          = 26,
  parameter int RATE_INIT       = RATE_INIT_DEF,
  parameter int RATE_MIN        = RATE_MIN_DEF,
  parameter int RATE_MAX        = RATE_MAX_DEF,
  parameter int STEP            = 1000,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_PERIOD   = 3000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_up_n,
  input  logic              sw_down_n,
  output logic [RATE_W-1:0] rate,
  output logic              rate_changed,
  output logic              at_limit
);

  localparam int EXT     = RATE_W + 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  if (!(RATE_MIN <= RATE_INIT && RATE_INIT <= RATE_MAX &&
        64'(RATE_MAX) < (64'd1 << RATE_W))) begin : g_param_err
    $error("button_rate_ctrl: need RATE_MIN <= RATE_INIT <= RATE_MAX < 2**RATE_W");
  end

  btn_t btn;

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .raw_n(sw_up_n), .pressed(btn.up)
  );
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk(clk), .reset(reset), .raw_n(sw_down_n), .pressed(btn.dn)
  );

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               dir, dir_n;  // 1 = up
  logic               do_step, step_up, active;
  logic [EXT-1:0]     step_val, sum, diff, up_val, dn_val;
  logic [RATE_W-1:0]  rate_n;
  logic               changed_n;

  assign active = dir ? btn.up : btn.dn;

  always_comb begin
    state_n = state;
    timer_n = timer;
    dir_n   = dir;
    do_step = 1'b0;
    step_up = dir;
    case (state)
      IDLE: begin
        if (btn.up && btn.dn) begin
          state_n = BLOCKED;
        end else if (btn.up ^ btn.dn) begin
          do_step = 1'b1;
          step_up = btn.up;
          dir_n   = btn.up;
          timer_n = TMR_W'(REPEAT_DELAY - 1);
          state_n = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (btn.up && btn.dn) begin
          state_n = BLOCKED;
        end else if (!active) begin
          state_n = IDLE;
        end else if (timer == '0) begin
          do_step = 1'b1;
          timer_n = TMR_W'(REPEAT_PERIOD - 1);
          state_n = REPEAT;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      BLOCKED: begin
        if (!btn.up && !btn.dn) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef BUTTON_RATE_ACCEL_EN
  logic [2:0] rep_cnt, rep_cnt_n;
  logic [2:0] shift, shift_n;

  always_comb begin
    rep_cnt_n = rep_cnt;
    shift_n   = shift;
    if (state_n == IDLE || state_n == BLOCKED) begin
      rep_cnt_n = '0;
      shift_n   = '0;
    end else if (state == REPEAT && do_step) begin
      if (rep_cnt == 3'(ACCEL_RUN - 1)) begin
        rep_cnt_n = '0;
        if (shift < 3'(ACCEL_MAX_SHIFT)) shift_n = shift + 1'b1;
      end else begin
        rep_cnt_n = rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
      shift   <= '0;
    end else begin
      rep_cnt <= rep_cnt_n;
      shift   <= shift_n;
    end
  end

  assign step_val = EXT'(STEP) << shift;
`else
  assign step_val = EXT'(STEP);
`endif

  // Saturating arithmetic one bit wider than rate so the down step cannot wrap.
  always_comb begin
    sum       = {1'b0, rate} + step_val;
    diff      = {1'b0, rate} - step_val;
    up_val    = (sum > EXT'(RATE_MAX)) ? EXT'(RATE_MAX) : sum;
    dn_val    = (diff[RATE_W] || diff < EXT'(RATE_MIN)) ? EXT'(RATE_MIN) : diff;
    rate_n    = rate;
    changed_n = 1'b0;
    if (do_step) begin
      rate_n    = RATE_W'(step_up ? up_val : dn_val);
      changed_n = (rate_n != rate);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      dir          <= 1'b0;
      rate         <= RATE_W'(RATE_INIT);
      rate_changed <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      dir          <= dir_n;
      rate         <= rate_n;
      rate_changed <= changed_n;
    end
  end

  assign at_limit = (rate == RATE_W'(RATE_MIN)) || (rate == RATE_W'(RATE_MAX));

endmodule

// File: tb/tb_button_rate_ctrl.sv
// Directed segment table for button_rate_ctrl at DEBUG scale, plus a reset-mid-repeat sequence.
module tb_button_rate_ctrl;
  import button_rate_pkg::*;

  localparam int RW = 26;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sw_up_n = 1'b1;
  logic          sw_down_n = 1'b1;
  logic [RW-1:0] rate;
  logic          rate_changed;
  logic          at_limit;

  button_rate_ctrl #(
    .RATE_W(RW),
    .RATE_INIT(DBG_RATE_INIT),
    .RATE_MIN(DBG_RATE_MIN),
    .RATE_MAX(DBG_RATE_MAX),
    .STEP(DBG_STEP),
    .DEBOUNCE_CYCLES(DBG_DEBOUNCE_CYCLES),
    .REPEAT_DELAY(DBG_REPEAT_DELAY),
    .REPEAT_PERIOD(DBG_REPEAT_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .sw_up_n(sw_up_n), .sw_down_n(sw_down_n),
    .rate(rate), .rate_changed(rate_changed), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // One segment: hold inputs for cyc cycles, then expect rate/at_limit and the pulse count seen.
  typedef struct {
    logic up_n;
    logic dn_n;
    int   cyc;
    int   rate;
    logic lim;
    int   pulses;
  } seg_t;

  seg_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rate_changed) pulses++;
  endtask

  task automatic run(input logic u, input logic d, input int n);
    sw_up_n   = u;
    sw_down_n = d;
    pulses    = 0;
    repeat (n) tick();
  endtask

  task automatic add(input logic u, input logic d, input int n, input int r,
                     input logic l, input int p);
    seg_t s;
    s.up_n = u; s.dn_n = d; s.cyc = n; s.rate = r; s.lim = l; s.pulses = p;
    vecs.push_back(s);
  endtask

  task automatic seg_check(input string tag, input int r, input logic l, input int p);
    check({tag, " rate"}, int'(rate), r);
    check({tag, " at_limit"}, int'(at_limit), int'(l));
    check({tag, " pulses"}, pulses, p);
  endtask

  initial begin
    // Bounce rejection: 2-cycle glitches never reach the 4-cycle debounce threshold.
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 2, 10, 0, 0);
      add(1, 1, 2, 10, 0, 0);
    end
    add(1, 1, 8, 10, 0, 0);
    // Single press: step lands exactly DEBOUNCE_CYCLES+3 cycles after the edge.
    add(0, 1, 6, 10, 0, 0);
    add(0, 1, 1, 11, 0, 1);
    add(0, 1, 8, 11, 0, 0);
    add(1, 1, 10, 11, 0, 0);
    // Auto-repeat: first step, +20 cycles, then every 5, saturating at 40.
    add(0, 1, 7, 12, 0, 1);
    add(0, 1, 19, 12, 0, 0);
    add(0, 1, 1, 13, 0, 1);
    add(0, 1, 4, 13, 0, 0);
    add(0, 1, 1, 14, 0, 1);
    add(0, 1, 130, 40, 1, 26);
    add(0, 1, 50, 40, 1, 0);
    add(1, 1, 10, 40, 1, 0);
    // Walk down to 6; one more repeat step lands while the release debounces.
    add(1, 0, 7, 39, 0, 1);
    add(1, 0, 20, 38, 0, 1);
    add(1, 0, 155, 7, 0, 31);
    add(1, 1, 10, 6, 0, 1);
    // Down saturation from 6.
    add(1, 0, 7, 5, 0, 1);
    add(1, 0, 20, 4, 1, 1);
    add(1, 0, 30, 4, 1, 0);
    add(1, 1, 10, 4, 1, 0);
    // Both buttons: blocked until fully released.
    add(0, 1, 7, 5, 0, 1);
    add(0, 0, 30, 5, 0, 0);
    add(1, 0, 20, 5, 0, 0);
    add(1, 1, 10, 5, 0, 0);
    add(1, 0, 7, 4, 1, 1);
    add(1, 1, 10, 4, 1, 0);

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset rate", int'(rate), 10);
    check("reset at_limit", int'(at_limit), 0);
    check("reset rate_changed", int'(rate_changed), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i].up_n, vecs[i].dn_n, vecs[i].cyc);
      seg_check($sformatf("seg%0d", i), vecs[i].rate, vecs[i].lim, vecs[i].pulses);
    end

    // Reset while in REPEAT with the button still held.
    run(0, 1, 30);
    seg_check("pre_reset", 6, 0, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset rate", int'(rate), 10);
    check("midreset rate_changed", int'(rate_changed), 0);
    run(0, 1, 6);
    seg_check("redebounce", 10, 0, 0);
    run(0, 1, 1);
    seg_check("fresh_step", 11, 0, 1);
    check("fresh_step rate_changed", int'(rate_changed), 1);
    tick();
    check("pulse one cycle", int'(rate_changed), 0);
    run(0, 1, 19);
    seg_check("hold_step", 12, 0, 1);
    run(0, 1, 40);
    seg_check("eight_repeats", 20, 0, 8);
`ifdef BUTTON_RATE_ACCEL_EN
    run(0, 1, 5);
    seg_check("ninth_repeat", 22, 0, 1);
    run(1, 1, 10);
    seg_check("accel_release", 24, 0, 1);
`else
    run(0, 1, 5);
    seg_check("ninth_repeat", 21, 0, 1);
    run(1, 1, 10);
    seg_check("accel_release", 22, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_rate_ctrl.md
Name: button_rate_ctrl

Overview:
Upstream control stage for the LED pulse generator. It synchronises and debounces the two active-low push buttons and turns presses and holds into a saturating `rate` value. That value feeds the divider comparing against `counter`, which advances the PWM sawtooth. It replaces the free-running `button_counter` stepping with press-edge steps plus hold-to-auto-repeat.

Parameters:
- RATE_W, 26, width of rate output.
- RATE_INIT, 800000, rate value after reset.
- RATE_MIN, 200000, lower saturation bound (inclusive).
- RATE_MAX, 3200000, upper saturation bound (inclusive).
- STEP, 1000, base increment/decrement per step.
- DEBOUNCE_CYCLES, 60000, consecutive stable cycles required to accept a new button level (1 ms at 60 MHz).
- REPEAT_DELAY, 30000000, hold cycles after the first step before auto-repeat starts (0.5 s).
- REPEAT_PERIOD, 3000000, cycles between auto-repeat steps (50 ms).

Ports:
- clk  in  1  system clock (60 MHz PLL output).
- reset  in  1  synchronous, active-high reset.
- sw_up_n  in  1  raw button, low = pressed; increases rate (slower pulse).
- sw_down_n  in  1  raw button, low = pressed; decreases rate (faster pulse).
- rate  out  RATE_W  current divider compare value.
- rate_changed  out  1  one-cycle pulse on the cycle after `rate` changes.
- at_limit  out  1  high while rate == RATE_MIN or rate == RATE_MAX.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state is cleared on a reset edge of clk.
- Reset values: rate = RATE_INIT; rate_changed = 0; at_limit = (RATE_INIT==RATE_MIN || RATE_INIT==RATE_MAX).
- Synchroniser: 2-flop chain per button; the synchroniser flops reset to 1 (released).
- Debounce, per button:
  - Counter clears whenever the synced input equals the debounced level.
  - Otherwise it counts up. On reaching DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Latency from a stable raw edge to the debounced edge is DEBOUNCE_CYCLES+2 cycles.
  - The debounced level resets to released.
- FSM states: IDLE, HOLD, REPEAT, BLOCKED.
  - IDLE: exactly one debounced button pressed -> apply one step in that direction, load the timer with REPEAT_DELAY-1, go to HOLD. Both pressed -> BLOCKED.
  - HOLD: timer decrements. Timer reaches 0 -> apply a step, load REPEAT_PERIOD-1, go to REPEAT. Active button released -> IDLE. Other button also pressed -> BLOCKED.
  - REPEAT: timer decrements. At 0 -> apply a step and reload REPEAT_PERIOD-1. Release -> IDLE. Both pressed -> BLOCKED.
  - BLOCKED: no steps. Leaves only when both buttons are debounced released -> IDLE. A press must be fully released before re-arming.
- Step arithmetic:
  - Computed in RATE_W+1 bits.
  - Up: rate = min(rate+STEP, RATE_MAX). Down: rate = max(rate−STEP, RATE_MIN). Underflow must not wrap.
  - A step at the limit leaves rate unchanged and produces no rate_changed pulse.
- Outputs: rate is registered and updates on the cycle after the step decision. rate_changed is registered and asserted for exactly one cycle per actual change.
- Reset mid-hold: returns to IDLE with rate = RATE_INIT. A button still held after reset must be re-debounced and then produces a fresh first step.
- Elaboration check: RATE_MIN ≤ RATE_INIT ≤ RATE_MAX < 2^RATE_W. Violation triggers `$error`.

Optional Feature:
- Macro: BUTTON_RATE_ACCEL_EN.
- When defined: in REPEAT, the step size doubles after every 8 consecutive repeat steps, capped at STEP<<4. It returns to STEP on entry to IDLE or BLOCKED. Saturation rules are unchanged.
- When undefined: the step is always STEP, and the acceleration counter/logic is not synthesised.

Decomposition:
- Shared package button_rate_pkg holds:
  - FSM state enum (IDLE, HOLD, REPEAT, BLOCKED).
  - Default constants RATE_INIT_DEF, RATE_MIN_DEF, RATE_MAX_DEF.
  - The DEBUG-scale constant set used by simulation.
- One natural sub-module, button_debounce: synchroniser plus stable counter, parameter CYCLES, instantiated twice.

Test Plan:
- Simulation parameters for all scenarios: DEBUG scale with RATE_INIT=10, RATE_MIN=4, RATE_MAX=40, STEP=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset and bounce rejection: after reset, rate=10 and at_limit=0. Toggle sw_up_n with 2-cycle glitches -> rate stays 10 and no rate_changed pulse.
- Single press and latency: hold sw_up_n low for 15 cycles -> rate 11 exactly DEBOUNCE_CYCLES+3 cycles after the edge, one rate_changed pulse, no further step.
- Auto-repeat and saturation: hold sw_up_n low -> first step, then the next step 20 cycles later, then every 5 cycles. At rate 40, at_limit=1 and no further rate_changed pulses.
- Down saturation: hold sw_down_n from rate 6 -> rate reaches 4, at_limit=1, and rate never goes below 4.
- Both buttons: press up, then down during HOLD -> no further steps. Release up only -> still no steps. Release both, press down -> rate −1.
- Reset mid-REPEAT: assert reset for 1 cycle while sw_up_n is held -> rate=10. After DEBOUNCE_CYCLES, a new first step gives rate 11. With BUTTON_RATE_ACCEL_EN defined, the step becomes 2 after the 8th repeat.
